instr_mem_banked_wrap: RTL and testbench

//  Instruction-memory wrapper: NUM_BANKS word-interleaved single-port SRAM banks plus a boot ROM region.

---
 rtl/instr_mem_banked_wrap.sv | 165 ++++++++++++++++
 tb/tb_instr_mem_banked_wrap.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_banked_wrap.sv
// Instruction-memory wrapper: word-interleaved single-port SRAM banks plus a boot ROM
// behind a req/gnt + rvalid/rready port with a one-entry response hold buffer.
module instr_mem_banked_wrap #(
    parameter int RAM_SIZE       = 32768,
    parameter int NUM_BANKS      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = $clog2(RAM_SIZE) + 1,
    parameter int ROM_ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    input  logic                    clr_err_i
);
    localparam int BYTES        = DATA_WIDTH / 8;
    localparam int OFF_BITS     = $clog2(BYTES);
    localparam int BANK_BITS    = $clog2(NUM_BANKS);
    localparam int BSEL_BITS    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int WA_BITS      = ADDR_WIDTH - 1 - OFF_BITS;
    localparam int ROW_BITS     = WA_BITS - BANK_BITS;
    localparam int ROWS         = RAM_SIZE / BYTES / NUM_BANKS;
    localparam int ROM_IDX_BITS = ROM_ADDR_WIDTH - OFF_BITS;
    localparam int ROM_WORDS    = 8;
    localparam int ROM_SEL_BITS = $clog2(ROM_WORDS);

    // Boot stub: set mtvec, clear a0/a1, then park in a wfi loop.
    localparam logic [31:0] ROM_IMAGE [ROM_WORDS] = '{
        32'h0000_0297, 32'h0202_8293, 32'h3052_9073, 32'h0000_0513,
        32'h0000_0593, 32'h1050_0073, 32'hFFDF_F06F, 32'h0000_0013
    };

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t                  state, state_nx;
    logic                    is_boot;
    logic [WA_BITS-1:0]      wa;
    logic [ROW_BITS-1:0]     row;
    logic [BSEL_BITS-1:0]    bank;
    logic [ROM_IDX_BITS-1:0] rom_idx;
    logic                    rd_go, wr_go;
    logic                    boot_q;
    logic [BSEL_BITS-1:0]    bank_sel_q;
    logic [DATA_WIDTH-1:0]   rom_q, hold_q, bank_data, resp_data;
    logic [DATA_WIDTH-1:0]   bank_q [NUM_BANKS];
    logic                    unused_addr;

    assign is_boot = addr_i[ADDR_WIDTH-1];
    assign wa      = addr_i[ADDR_WIDTH-2:OFF_BITS];
    assign row     = wa[WA_BITS-1:BANK_BITS];
    assign rom_idx = addr_i[ROM_ADDR_WIDTH-1:OFF_BITS];

    generate
        if (BANK_BITS == 0) begin : g_one_bank
            assign bank      = '0;
            assign bank_data = bank_q[0];
        end else begin : g_multi_bank
            assign bank      = wa[BANK_BITS-1:0];
            assign bank_data = bank_q[bank_sel_q];
        end
        if (OFF_BITS > 0) begin : g_off
            assign unused_addr = ^addr_i[OFF_BITS-1:0];
        end else begin : g_no_off
            assign unused_addr = 1'b0;
        end
    endgenerate

    assign rvalid_o = (state != IDLE);
    assign gnt_o    = req_i & ~rst & ~(rvalid_o & ~rready_i);
    assign rd_go    = gnt_o & ~we_i;
    assign wr_go    = gnt_o & we_i;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [ROWS];
        logic [DATA_WIDTH-1:0] q;
        logic                  en;

        assign en = gnt_o & ~is_boot & (bank == BSEL_BITS'(b));

        // NOTE: the SRAM array and its read register carry no reset; contents are defined only once written.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we_i) begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (be_i[i]) mem[row][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end else begin
                    q <= mem[row];
                end
            end
        end

        assign bank_q[b] = q;
    end

    function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ROM_IDX_BITS-1:0] idx);
        if (idx < ROM_IDX_BITS'(ROM_WORDS)) return DATA_WIDTH'(ROM_IMAGE[idx[ROM_SEL_BITS-1:0]]);
        return '0;
    endfunction

    always_ff @(posedge clk) begin
        if (rd_go && is_boot) rom_q <= rom_word(rom_idx);
    end

    // The read select is registered so the response mux follows the source chosen at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_q     <= 1'b0;
            bank_sel_q <= '0;
        end else if (rd_go) begin
            boot_q     <= is_boot;
            bank_sel_q <= bank;
        end
    end

    assign resp_data = boot_q ? rom_q : bank_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (rd_go) state_nx = RESP;
            RESP, HOLD: begin
                if (rready_i) state_nx = rd_go ? RESP : IDLE;
                else          state_nx = HOLD;
            end
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                            hold_q <= '0;
        else if (state == RESP && !rready_i) hold_q <= resp_data;
    end

    always_comb begin
        rdata_o = '0;
        case (state)
            RESP:    rdata_o = resp_data;
            HOLD:    rdata_o = hold_q;
            default: rdata_o = '0;
        endcase
    end

    // A boot write in the same cycle as clr_err_i keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst)                  err_o <= 1'b0;
        else if (wr_go && is_boot) err_o <= 1'b1;
        else if (clr_err_i)       err_o <= 1'b0;
    end

endmodule

// File: tb/tb_instr_mem_banked_wrap.sv
// Scoreboard bench: three wrappers (1, 2 and 4 banks) share one stimulus stream and are
// checked every cycle against a byte-level memory model and a queue of expected responses.
module tb_instr_mem_banked_wrap;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_i = 1'b0, we_i = 1'b0, rready_i = 1'b1, clr_err_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [3:0]    be_i = '0;
    logic          gnt_w [3];
    logic          rvalid_w [3];
    logic          err_w [3];
    logic [DW-1:0] rdata_w [3];

    int            total = 0;
    int            bad = 0;
    logic          mon_en = 1'b0;
    logic          rand_rready = 1'b0;
    logic          exp_err = 1'b0;
    logic [DW-1:0] exp_q [$];
    logic [7:0]    ram_b [int];
    logic [31:0]   rom_tbl [8] = '{
        32'h0000_0297, 32'h0202_8293, 32'h3052_9073, 32'h0000_0513,
        32'h0000_0593, 32'h1050_0073, 32'hFFDF_F06F, 32'h0000_0013
    };

    always #5 clk = ~clk;

    instr_mem_banked_wrap #(.NUM_BANKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_w[0]), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_w[0]), .rready_i(rready_i),
        .rdata_o(rdata_w[0]), .err_o(err_w[0]), .clr_err_i(clr_err_i));
    instr_mem_banked_wrap #(.NUM_BANKS(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_w[1]), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_w[1]), .rready_i(rready_i),
        .rdata_o(rdata_w[1]), .err_o(err_w[1]), .clr_err_i(clr_err_i));
    instr_mem_banked_wrap #(.NUM_BANKS(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_w[2]), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_w[2]), .rready_i(rready_i),
        .rdata_o(rdata_w[2]), .err_o(err_w[2]), .clr_err_i(clr_err_i));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference read: ROM words past the image read as 0, RAM bytes never written read as 0.
    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        logic [31:0] v;
        int          base;
        v = '0;
        if (a[15]) begin
            if (a[11:2] < 10'd8) v = rom_tbl[a[4:2]];
        end else begin
            base = int'(a[14:2]) * 4;
            for (int i = 0; i < 4; i++) v[8*i +: 8] = ram_b.exists(base + i) ? ram_b[base + i] : 8'h00;
        end
        return v;
    endfunction

    // Drive one request, wait for its grant, then update the model / push the expected read data.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] be);
        int base;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
        for (int n = 0; ; n++) begin
            @(negedge clk); #1;
            if (gnt_w[1]) begin
                if (!we) begin
                    exp_q.push_back(model_read(a));
                end else if (!a[15]) begin
                    base = int'(a[14:2]) * 4;
                    for (int i = 0; i < 4; i++) if (be[i]) ram_b[base + i] = wd[8*i +: 8];
                end
                break;
            end
            if (n >= 200) begin
                check("gnt_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: per-cycle grant/response/error expectations derived from inputs and the scoreboard.
    initial begin
        logic ev, eg, set;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ev = (exp_q.size() != 0);
                eg = req_i & ~rst & ~(ev & ~rready_i);
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("rvalid%0d", k), 32'(rvalid_w[k]), 32'(ev));
                    if (ev) check($sformatf("rdata%0d", k), rdata_w[k], exp_q[0]);
                    check($sformatf("gnt%0d", k), 32'(gnt_w[k]), 32'(eg));
                    check($sformatf("err%0d", k), 32'(err_w[k]), 32'(exp_err));
                end
                set = eg & we_i & addr_i[15];
                if (rst) begin
                    exp_q.delete();
                    exp_err = 1'b0;
                end else begin
                    if (ev && rready_i) void'(exp_q.pop_front());
                    exp_err = set ? 1'b1 : (clr_err_i ? 1'b0 : exp_err);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rready) rready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic          we;

        // Reset state, with a request pending to show the grant is masked.
        req_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_gnt%0d", k), 32'(gnt_w[k]), 32'd0);
            check($sformatf("rst_rvalid%0d", k), 32'(rvalid_w[k]), 32'd0);
            check($sformatf("rst_rdata%0d", k), rdata_w[k], 32'd0);
            check($sformatf("rst_err%0d", k), 32'(err_w[k]), 32'd0);
        end
        req_i = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;

        // Zero the RAM windows used below.
        for (int w = 0; w < 64; w++) begin
            issue(1'b1, 16'(w * 4), 32'd0, 4'hF);
            issue(1'b1, 16'(16'h7F00 + w * 4), 32'd0, 4'hF);
        end

        // Back-to-back reads across both banks.
        issue(1'b1, 16'h0000, 32'hA5A5_0001, 4'hF);
        issue(1'b1, 16'h0004, 32'h5A5A_0002, 4'hF);
        issue(1'b0, 16'h0000, 32'd0, 4'h0);
        check("t1_rd0", rdata_w[1], 32'hA5A5_0001);
        issue(1'b0, 16'h0004, 32'd0, 4'h0);
        check("t1_rd1", rdata_w[1], 32'h5A5A_0002);
        idle(1);

        // Byte-enabled write.
        issue(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'b0101);
        check("t2_wr_no_rvalid", 32'(rvalid_w[1]), 32'd0);
        issue(1'b0, 16'h0010, 32'd0, 4'h0);
        check("t2_rd", rdata_w[1], 32'h00AD_00EF);
        idle(1);

        // Stalled ROM response with the next request pending.
        issue(1'b0, 16'h8000, 32'd0, 4'h0);
        rready_i = 1'b0;
        fork
            issue(1'b0, 16'h8004, 32'd0, 4'h0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t3_stall_gnt", 32'(gnt_w[1]), 32'd0);
                    check("t3_stall_rdata", rdata_w[1], 32'h0000_0297);
                end
                @(posedge clk); #1;
                rready_i = 1'b1;
            end
        join
        check("t3_next_rd", rdata_w[1], 32'h0202_8293);
        idle(1);

        // Boot write protection and sticky error.
        issue(1'b1, 16'h8004, 32'hFFFF_FFFF, 4'hF);
        check("t4_err_set", 32'(err_w[1]), 32'd1);
        idle(1);
        check("t4_err_sticky", 32'(err_w[1]), 32'd1);
        clr_err_i = 1'b1;
        idle(1);
        clr_err_i = 1'b0;
        check("t4_err_clr", 32'(err_w[1]), 32'd0);
        issue(1'b1, 16'h800C, 32'h1234_5678, 4'hF);
        clr_err_i = 1'b1;
        issue(1'b1, 16'h8008, 32'h1234_5678, 4'hF);
        clr_err_i = 1'b0;
        check("t4_set_wins", 32'(err_w[1]), 32'd1);
        issue(1'b0, 16'h8004, 32'd0, 4'h0);
        check("t4_rom_intact", rdata_w[1], 32'h0202_8293);
        idle(1);

        // Reset one cycle after a granted read, with the response stalled.
        issue(1'b0, 16'h0004, 32'd0, 4'h0);
        rst = 1'b1;
        rready_i = 1'b0;
        idle(1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t5_rvalid%0d", k), 32'(rvalid_w[k]), 32'd0);
            check($sformatf("t5_err%0d", k), 32'(err_w[k]), 32'd0);
        end
        idle(3);
        rready_i = 1'b1;
        idle(2);
        check("t5_no_stale", 32'(rvalid_w[1]), 32'd0);

        // Random mix over RAM windows and ROM with random rready gaps and error clears.
        rand_rready = 1'b1;
        for (int t = 0; t < 256; t++) begin
            case ($urandom_range(0, 2))
                0:       a = 16'($urandom_range(0, 63) * 4);
                1:       a = 16'(16'h7F00 + $urandom_range(0, 63) * 4);
                default: a = 16'h8000 | 16'($urandom_range(0, 7) << 12) | 16'($urandom_range(0, 15) << 2);
            endcase
            we = ($urandom_range(0, 2) == 0);
            clr_err_i = ($urandom_range(0, 7) == 0);
            issue(we, a, $urandom, 4'($urandom_range(0, 15)));
            clr_err_i = 1'b0;
            idle($urandom_range(0, 2));
        end
        rand_rready = 1'b0;
        @(posedge clk); #2;
        rready_i = 1'b1;
        idle(4);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
